// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction-fetch / datapath memory arbiter.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_DP_BUSY = 2'd2
  } arb_state_e;

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_DP = 1'b1
  } grant_e;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter for the arbiter; flags a memory access that has waited TIMEOUT cycles.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy,
  input  logic ack,
  output logic expire
);
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Held at zero while idle, so every grant starts counting from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (!busy) begin
      cnt_d = '0;
    end else if (!ack) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = busy && !ack && (cnt_q == LIMIT);
endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / datapath) single-port memory arbiter with alternating priority.
// Optional watchdog and sticky err output are enabled with `define MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          start_up_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          dp_req,
  input  logic          dp_we,
  input  logic [AW-1:0] dp_addr,
  input  logic [DW-1:0] dp_wdata,
  output logic          dp_ack,
  output logic [DW-1:0] dp_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic          err
`endif
);
  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must lie in 2..255");
  end

  arb_state_e    state_q, state_d;
  grant_e        last_grant_q, last_grant_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          dp_ack_q, dp_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dp_rdata_q, dp_rdata_d;
  logic          if_pend, dp_pend, pick_dp, expire;

  // A request still high in its own ack cycle is the finished one, not a new one.
  assign if_pend = if_req && !if_ack_q;
  assign dp_pend = dp_req && !dp_ack_q;
  assign pick_dp = dp_pend && (!if_pend || (last_grant_q == GRANT_IF));

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q, err_d;

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (start_up_n),
    .busy  (state_q != ST_IDLE),
    .ack   (mem_ack),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = 1'b0;
    dp_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    dp_rdata_d   = dp_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    err_d        = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_dp) begin
          state_d      = ST_DP_BUSY;
          last_grant_d = GRANT_DP;
          mem_req_d    = 1'b1;
          mem_we_d     = dp_we;
          mem_addr_d   = dp_addr;
          mem_wdata_d  = dp_wdata;
        end else if (if_pend) begin
          state_d      = ST_IF_BUSY;
          last_grant_d = GRANT_IF;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = if_addr;
        end
      end
      ST_IF_BUSY, ST_DP_BUSY: begin
        // A watchdog expiry completes the access with zero data.
        if (mem_ack || expire) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          if (state_q == ST_IF_BUSY) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            dp_ack_d   = 1'b1;
            dp_rdata_d = mem_ack ? mem_rdata : '0;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          if (!mem_ack) begin
            err_d = 1'b1;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge start_up_n) begin
    if (!start_up_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_DP;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      dp_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      dp_rdata_q   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      dp_ack_q     <= dp_ack_d;
      if_rdata_q   <= if_rdata_d;
      dp_rdata_q   <= dp_rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q        <= err_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ack    = if_ack_q;
  assign dp_ack    = dp_ack_q;
  assign if_rdata  = if_rdata_q;
  assign dp_rdata  = dp_rdata_q;
  assign stall     = if_pend || dp_pend;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err       = err_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, corner sequences, randomized traffic vs reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          start_up_n;
  logic          if_req, if_ack, dp_req, dp_we, dp_ack;
  logic [AW-1:0] if_addr, dp_addr, mem_addr;
  logic [DW-1:0] if_rdata, dp_wdata, dp_rdata, mem_wdata, mem_rdata;
  logic          mem_req, mem_we, mem_ack, stall;
`ifdef MEM_ARB_TIMEOUT_EN
  logic          err;
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .start_up_n(start_up_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr), .dp_wdata(dp_wdata),
    .dp_ack(dp_ack), .dp_rdata(dp_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall)
`ifdef MEM_ARB_TIMEOUT_EN
    , .err(err)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mlat = 1;
  int mcnt = 0;
  bit mem_rand = 0;
  logic [DW-1:0] mresp = '0;

  typedef struct {
    bit          ifr;
    logic [31:0] ifa;
    bit          dpr;
    bit          dpw;
    logic [31:0] dpa;
    logic [31:0] dpd;
    int          lat;
    logic [31:0] rd;
    bit          dp_first;
    int          if_ack_at;
    int          dp_ack_at;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: acks mlat cycles after mem_req rises.
  task automatic step();
    @(posedge clk);
    #1;
    if (mem_req) begin
      if (mcnt == 0 && mem_rand) begin
        mlat  = $urandom_range(3, 1);
        mresp = $urandom();
      end
      mem_ack = (mcnt == mlat);
      if (mem_ack) mem_rdata = mresp;
      else if (mem_rand) mem_rdata = $urandom();
      mcnt++;
    end else begin
      mem_ack = 1'b0;
      mcnt = 0;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start_up_n = 1'b0;
    if_req = 0; dp_req = 0; dp_we = 0;
    if_addr = '0; dp_addr = '0; dp_wdata = '0;
    mem_ack = 0; mem_rdata = '0; mcnt = 0;
    repeat (2) @(negedge clk);
    start_up_n = 1'b1;
    cyc = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  last;
    int  second_rise;
    bit  dp_turn;
    do_reset();
    mem_rand = 0; mlat = v.lat; mresp = v.rd;
    if_req = v.ifr; if_addr = v.ifa;
    dp_req = v.dpr; dp_we = v.dpw; dp_addr = v.dpa; dp_wdata = v.dpd;
    last = (v.if_ack_at > v.dp_ack_at) ? v.if_ack_at : v.dp_ack_at;
    second_rise = (v.ifr && v.dpr) ? ((v.dp_first ? v.dp_ack_at : v.if_ack_at) + 1) : -1;
    for (int c = 1; c <= last + 2; c++) begin
      step();
      chk($sformatf("v%0d if_ack", idx), if_ack, c == v.if_ack_at);
      chk($sformatf("v%0d dp_ack", idx), dp_ack, c == v.dp_ack_at);
      chk($sformatf("v%0d stall", idx), stall,
          (if_req && c < v.if_ack_at) || (dp_req && c < v.dp_ack_at));
      if (c == 1 || c == second_rise) begin
        dp_turn = (c == 1) ? v.dp_first : !v.dp_first;
        chk($sformatf("v%0d mem_req", idx), mem_req, 1'b1);
        chk($sformatf("v%0d mem_addr", idx), mem_addr, dp_turn ? v.dpa : v.ifa);
        chk($sformatf("v%0d mem_we", idx), mem_we, dp_turn ? v.dpw : 1'b0);
        if (dp_turn && v.dpw) chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.dpd);
      end
      if (c == v.if_ack_at) begin
        chk($sformatf("v%0d if_rdata", idx), if_rdata, v.rd);
        chk($sformatf("v%0d mem_req_drop", idx), mem_req, 1'b0);
        if_req = 0;
      end
      if (c == v.dp_ack_at) begin
        if (!v.dpw) chk($sformatf("v%0d dp_rdata", idx), dp_rdata, v.rd);
        chk($sformatf("v%0d mem_req_drop", idx), mem_req, 1'b0);
        dp_req = 0;
      end
    end
  endtask

  task automatic seq_b2b();
    int rise_cyc[8];
    logic [31:0] rise_addr[8];
    int nrise;
    int low_cnt;
    bit prev;
    do_reset();
    mem_rand = 0; mlat = 1; mresp = 32'hABCD_0000;
    if_req = 1; if_addr = 32'h1000; dp_req = 1; dp_we = 0; dp_addr = 32'h2000;
    nrise = 0; low_cnt = 0; prev = 0;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (mem_req && !prev && nrise < 8) begin
        rise_cyc[nrise] = c; rise_addr[nrise] = mem_addr; nrise++;
      end
      if (!mem_req && c > 1 && c < 10) low_cnt++;
      prev = mem_req;
    end
    if_req = 0; dp_req = 0;
    chk("b2b rises", (nrise >= 4), 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("b2b rise%0d cycle", k), rise_cyc[k], 1 + 3 * k);
      chk($sformatf("b2b rise%0d owner", k), rise_addr[k], (k % 2 == 0) ? 32'h1000 : 32'h2000);
    end
    chk("b2b idle cycles", low_cnt, 3);
    repeat (4) step();
  endtask

  task automatic seq_reset_mid();
    do_reset();
    mem_rand = 0; mlat = 255;
    dp_req = 1; dp_we = 1; dp_addr = 32'h80; dp_wdata = 32'h1212_1212;
    repeat (3) step();
    chk("rmid busy mem_req", mem_req, 1'b1);
    chk("rmid busy mem_we", mem_we, 1'b1);
    start_up_n = 0; dp_req = 0;
    #1;
    chk("rmid mem_req", mem_req, 1'b0);
    chk("rmid mem_we", mem_we, 1'b0);
    chk("rmid mem_addr", mem_addr, 32'h0);
    chk("rmid mem_wdata", mem_wdata, 32'h0);
    chk("rmid dp_ack", dp_ack, 1'b0);
    @(negedge clk);
    start_up_n = 1;
    mem_ack = 1; mem_rdata = 32'h9999_9999;
    cyc = 0;
    for (int c = 1; c <= 2; c++) begin
      step();
      chk("rmid late dp_ack", dp_ack, 1'b0);
      chk("rmid late if_ack", if_ack, 1'b0);
      chk("rmid late mem_req", mem_req, 1'b0);
      chk("rmid late dp_rdata", dp_rdata, 32'h0);
      chk("rmid late if_rdata", if_rdata, 32'h0);
    end
    mlat = 1; mresp = 32'h0BAD_F00D;
    if_req = 1; if_addr = 32'h300; cyc = 0;
    step();
    chk("rmid idle grant", mem_req, 1'b1);
    chk("rmid idle addr", mem_addr, 32'h300);
    step(); step();
    chk("rmid after if_ack", if_ack, 1'b1);
    chk("rmid after if_rdata", if_rdata, 32'h0BAD_F00D);
    if_req = 0;
    step();
  endtask

  task automatic seq_stray();
    do_reset();
    mem_rand = 0; mlat = 1; mresp = 32'h7777_0001;
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    step();
    chk("stray if_ack", if_ack, 1'b0);
    chk("stray dp_ack", dp_ack, 1'b0);
    chk("stray mem_req", mem_req, 1'b0);
    chk("stray if_rdata", if_rdata, 32'h0);
    chk("stray dp_rdata", dp_rdata, 32'h0);
    if_req = 1; if_addr = 32'h500; dp_req = 1; dp_we = 0; dp_addr = 32'h600; cyc = 0;
    step();
    chk("stray first owner", mem_addr, 32'h500);
    step(); step();
    chk("stray if_ack later", if_ack, 1'b1);
    if_req = 0;
    step();
    chk("stray second owner", mem_addr, 32'h600);
    step(); step();
    chk("stray dp_ack later", dp_ack, 1'b1);
    chk("stray dp_rdata later", dp_rdata, 32'h7777_0001);
    dp_req = 0;
    step();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic seq_timeout();
    do_reset();
    mem_rand = 0; mlat = 1; mresp = 32'h3C3C_3C3C;
    chk("to err reset", err, 1'b0);
    dp_req = 1; dp_we = 0; dp_addr = 32'h700;
    repeat (3) step();
    chk("to pre dp_rdata", dp_rdata, 32'h3C3C_3C3C);
    dp_req = 0;
    step();
    mlat = 255; dp_req = 1; cyc = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("to dp_ack timing", dp_ack, c == 5);
      chk("to err", err, c == 5);
    end
    chk("to dp_rdata zero", dp_rdata, 32'h0);
    chk("to mem_req drop", mem_req, 1'b0);
    dp_req = 0;
    step();
    mlat = 1; mresp = 32'h1357_9BDF; if_req = 1; if_addr = 32'h800;
    repeat (3) step();
    chk("to next if_ack", if_ack, 1'b1);
    chk("to next if_rdata", if_rdata, 32'h1357_9BDF);
    chk("to err sticky", err, 1'b1);
    if_req = 0;
    step();
  endtask
`endif

  // Reference model: one grant per free edge, alternating under contention, ack one edge after mem_ack.
  task automatic run_random(input int ncyc);
    bit s_if, s_dp, s_ack, prev_req, lg_dp, win_dp, e_if, e_dp;
    logic [31:0] s_rd;
    int owner, if_gap, dp_gap;
    do_reset();
    mem_rand = 1;
    owner = 0; lg_dp = 1; if_gap = 0; dp_gap = 0;
    s_if = 0; s_dp = 0; s_ack = 0; s_rd = '0; prev_req = 0;
    for (int c = 0; c < ncyc; c++) begin
      step();
      e_if = 0; e_dp = 0;
      if (owner != 0 && s_ack) begin
        e_if = (owner == 1); e_dp = (owner == 2);
        if (owner == 1) chk("rnd if_rdata", if_rdata, s_rd);
        else if (!dp_we) chk("rnd dp_rdata", dp_rdata, s_rd);
        chk("rnd mem_req after ack", mem_req, 1'b0);
        owner = 0;
      end else if (owner == 0 && (s_if || s_dp)) begin
        win_dp = s_dp && (!s_if || !lg_dp);
        chk("rnd grant", {prev_req, mem_req}, 2'b01);
        chk("rnd grant addr", mem_addr, win_dp ? dp_addr : if_addr);
        chk("rnd grant we", mem_we, win_dp ? dp_we : 1'b0);
        if (win_dp && dp_we) chk("rnd grant wdata", mem_wdata, dp_wdata);
        owner = win_dp ? 2 : 1;
        lg_dp = win_dp;
      end else begin
        chk("rnd mem_req hold", mem_req, owner != 0);
      end
      chk("rnd if_ack", if_ack, e_if);
      chk("rnd dp_ack", dp_ack, e_dp);
      chk("rnd stall", stall, (if_req && !e_if) || (dp_req && !e_dp));
      if (e_if) begin
        if_req = 0; if_gap = $urandom_range(3, 1);
      end else if (!if_req) begin
        if (if_gap > 0) if_gap--;
        else if ($urandom_range(1, 0) == 1) begin
          if_req = 1; if_addr = $urandom();
        end
      end
      if (e_dp) begin
        dp_req = 0; dp_gap = $urandom_range(3, 1);
      end else if (!dp_req) begin
        if (dp_gap > 0) dp_gap--;
        else if ($urandom_range(1, 0) == 1) begin
          dp_req = 1; dp_we = 1'($urandom_range(1, 0)); dp_addr = $urandom(); dp_wdata = $urandom();
        end
      end
      prev_req = mem_req;
      s_if = if_req; s_dp = dp_req; s_ack = mem_ack; s_rd = mem_rdata;
    end
    if_req = 0; dp_req = 0;
    repeat (6) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{1, 32'h0000_0010, 0, 0, 32'h0,   32'h0,         1, 32'h8C01_0004, 0, 3, -1};
    vecs[1] = '{0, 32'h0,         1, 0, 32'h20,  32'h0,         1, 32'h1234_5678, 1, -1, 3};
    vecs[2] = '{0, 32'h0,         1, 1, 32'h40,  32'hDEAD_BEEF, 2, 32'h1111_2222, 1, -1, 4};
    vecs[3] = '{1, 32'h100,       1, 1, 32'h40,  32'hDEAD_BEEF, 1, 32'hCAFE_F00D, 0, 3, 6};
    vecs[4] = '{1, 32'hFFFF_FFFC, 1, 0, 32'h0,   32'h0,         3, 32'h0F0F_0F0F, 0, 5, 10};
    vecs[5] = '{1, 32'hAAAA_5554, 0, 0, 32'h0,   32'h0,         3, 32'h7654_3210, 0, 5, -1};

    start_up_n = 0;
    if_req = 0; dp_req = 0; dp_we = 0; if_addr = '0; dp_addr = '0; dp_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    #1;
    chk("reset mem_req", mem_req, 1'b0);
    chk("reset mem_we", mem_we, 1'b0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset mem_wdata", mem_wdata, 32'h0);
    chk("reset acks", {if_ack, dp_ack}, 2'b00);
    chk("reset rdata", {if_rdata, dp_rdata}, 64'h0);
    chk("reset stall", stall, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
    seq_b2b();
    seq_reset_mid();
    seq_stray();
`ifdef MEM_ARB_TIMEOUT_EN
    seq_timeout();
`endif
    run_random(1500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line: AW, 32, address width; DW, 32, data width; TIMEOUT, 16, watchdog limit in cycles (range 2..255).
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset are listed first.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 start_up_n  in  1  reset, asynchronous, active-low.
REQ-005 if_req  in  1  instruction fetch read request; if_addr  in  AW  fetch address.
REQ-006 if_ack  out  1  one-cycle pulse, fetch complete; if_rdata  out  DW  fetched word, valid while if_ack is high.
REQ-007 dp_req  in  1  datapath load/store request; dp_we  in  1  1 = store; dp_addr  in  AW  address; dp_wdata  in  DW  store data.
REQ-008 dp_ack  out  1  one-cycle pulse, datapath access complete; dp_rdata  out  DW  load data, valid while dp_ack is high.
REQ-009 mem_req  out  1  memory request, held high until mem_ack; mem_we  out  1  write enable; mem_addr  out  AW  address; mem_wdata  out  DW  write data.
REQ-010 mem_ack  in  1  memory completion pulse; mem_rdata  in  DW  read data, valid with mem_ack.
REQ-011 stall  out  1  processor stall; high while any request is pending without its ack.
REQ-012 err  out  1  sticky timeout flag; present only with MEM_ARB_TIMEOUT_EN.

Function
REQ-013 FSM states: IDLE, IF_BUSY, DP_BUSY.
REQ-014 Requester protocol: the requester holds req, addr, we and wdata stable from assertion until its ack cycle, and may drop req in the cycle after ack.
REQ-015 From IDLE, a sole pending requester is granted on the next edge, entering IF_BUSY or DP_BUSY.
REQ-016 On a grant, the arbiter registers the winner's address, write enable and write data onto the mem_* outputs and sets mem_req high.
REQ-017 When if_req and dp_req are both high in IDLE, the winner is chosen by the last_grant bit: dp wins if last_grant=IF; if wins if last_grant=DP.
REQ-018 The last_grant bit is updated on every grant.
REQ-019 mem_req and mem_* stay constant while in a BUSY state.
REQ-020 On mem_ack in a BUSY state, next edge: the owner's ack pulses for one cycle, rdata is captured from mem_rdata, mem_req drops, and the FSM returns to IDLE.
REQ-021 Latency: minimum 3 cycles from req to ack when the memory acks in the cycle after mem_req rises.
REQ-022 The edge that issues an ack does not issue a new grant; one idle cycle is mandatory between memory transactions.
REQ-023 A store returns dp_ack, and dp_rdata is don't-care for stores.
REQ-024 mem_ack received in IDLE is ignored.
REQ-025 A req dropped before its grant is not serviced. A req dropped after its grant still completes and acks.
REQ-026 stall is combinational: (if_req & ~if_ack) | (dp_req & ~dp_ack).

Reset
REQ-027 Asserting start_up_n low at any time, including mid-transaction, forces: FSM=IDLE, last_grant=DP, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, dp_ack=0, if_rdata=0, dp_rdata=0, err=0.
REQ-028 An in-flight transaction is abandoned on reset, and a late mem_ack arriving after reset is ignored.

Configuration
REQ-029 Macro MEM_ARB_TIMEOUT_EN defined: an 8-bit counter clears on grant and increments each BUSY cycle without mem_ack.
REQ-030 On reaching TIMEOUT, next edge: the owner's ack pulses with rdata=0, mem_req drops, err sets and stays set until reset, and the FSM returns to IDLE.
REQ-031 Macro MEM_ARB_TIMEOUT_EN undefined: no counter and no err port; BUSY waits indefinitely for mem_ack.

Structure
REQ-032 A shared include file holds the FSM state encodings (IDLE=2'd0, IF_BUSY=2'd1, DP_BUSY=2'd2), the last_grant encodings, and default AW/DW.
REQ-033 One sub-module, mem_arb_watchdog, holds the timeout counter; it is instantiated only under MEM_ARB_TIMEOUT_EN.
REQ-034 Target size: 150-300 lines of RTL.

Verification
REQ-035 Sole fetch: if_req=1, if_addr=0x0000_0010, memory acks 1 cycle after mem_req with rdata 0x8C01_0004 -> mem_addr=0x10, mem_we=0; if_ack pulses at cycle 3 with if_rdata=0x8C01_0004; stall is high for cycles 0-2.
REQ-036 Simultaneous requests from reset: if_req=1 and dp_req=1 (dp_we=1, addr 0x40, wdata 0xDEAD_BEEF) -> fetch is granted first (last_grant=DP at reset); after if_ack and the idle cycle, mem_we=1, mem_addr=0x40, mem_wdata=0xDEAD_BEEF, then dp_ack.
REQ-037 Back-to-back contention: both requests held for 4 transactions -> grants alternate IF, DP, IF, DP, and exactly one idle cycle separates each pair of mem_req pulses.
REQ-038 Reset mid-transaction: start_up_n=0 while in DP_BUSY, then a late mem_ack after release -> all outputs are 0, no dp_ack is issued, and the FSM is IDLE.
REQ-039 Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT=4): dp_req with memory never acking -> dp_ack pulses 4 cycles after the grant with dp_rdata=0, err=1 and stays high, and the next if_req is serviced normally.
REQ-040 Stray ack: mem_ack pulsed while in IDLE -> no ack output and no state change.
